// File: rtl/acq_viewport_ram.sv
// Acquisition ring buffer with arm/trigger/post-trigger capture, plus a VME
// viewport that shares the single RAM port (acquisition writes always win).
module acq_viewport_ram #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] VMEAddr,
  input  logic [15:0]           VMEWrData,
  input  logic                  VMERdMem,
  input  logic                  VMEWrMem,
  output logic [15:0]           VMERdData,
  output logic                  VMERdDone,
  output logic                  VMEWrDone,
  input  logic [15:0]           acq_data_i,
  input  logic                  acq_valid_i,
  input  logic                  arm_i,
  input  logic                  trigger_i,
  input  logic [ADDR_WIDTH-1:0] post_trig_i,
  output logic                  acq_busy_o,
  output logic                  acq_done_o,
  output logic                  wrapped_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] trig_addr_o
);
  // state     | meaning
  // ST_IDLE   | nothing captured yet, waiting for arm
  // ST_ARMED  | storing pre-trigger samples around the ring
  // ST_TRIG   | storing post-trigger samples until the target count
  // ST_DONE   | capture frozen, waiting for the next arm
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_TRIG, ST_DONE} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_trig_addr, r_remain, w_post_tgt;
  logic                  r_wrapped;
  logic                  r_rd_pend, r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_rd_done, r_wr_done;
  logic [15:0]           r_rd_data;
  logic [15:0]           r_mem [DEPTH];
  logic                  w_acq_active, w_capture;
  logic                  w_rd_issue, w_wr_issue, w_wr_commit, w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [15:0]           w_ram_wdata;

  assign w_acq_active = (r_state == ST_ARMED) || (r_state == ST_TRIG);
  // An arm edge restarts the capture, so a sample on that edge is not stored.
  assign w_capture    = acq_valid_i && w_acq_active && !arm_i;
  assign w_post_tgt   = (post_trig_i == '0) ? ADDR_WIDTH'(1) : post_trig_i;

  always_comb begin
    w_state_nxt = r_state;
    if (arm_i) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: if (trigger_i)
                    w_state_nxt = (acq_valid_i && w_post_tgt == ADDR_WIDTH'(1)) ? ST_DONE : ST_TRIG;
        ST_TRIG:  if (acq_valid_i && r_remain == ADDR_WIDTH'(1))
                    w_state_nxt = ST_DONE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_trig_addr <= '0;
      r_remain    <= '0;
      r_wrapped   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (arm_i) begin
        r_wr_ptr    <= '0;
        r_trig_addr <= '0;
        r_remain    <= '0;
        r_wrapped   <= 1'b0;
      end else begin
        // r_remain counts down the post-trigger samples still to be stored
        if (r_state == ST_ARMED && trigger_i) begin
          r_trig_addr <= r_wr_ptr;
          r_remain    <= acq_valid_i ? w_post_tgt - ADDR_WIDTH'(1) : w_post_tgt;
        end else if (r_state == ST_TRIG && acq_valid_i) begin
          r_remain <= r_remain - ADDR_WIDTH'(1);
        end
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
          if (&r_wr_ptr) r_wrapped <= 1'b1;
        end
      end
    end
  end

  assign w_rd_issue  = r_rd_pend && !w_capture;
  assign w_wr_issue  = r_wr_pend && !w_capture && !r_rd_pend;
  // Writes during a capture are acknowledged but never reach the buffer.
  assign w_wr_commit = w_wr_issue && !w_acq_active;
  assign w_ram_we    = w_capture || w_wr_commit;
  assign w_ram_addr  = w_capture ? r_wr_ptr : (w_rd_issue ? r_rd_addr : r_wr_addr);
  assign w_ram_wdata = w_capture ? acq_data_i : r_wr_data;

  always_ff @(posedge Clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_done <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (VMERdMem) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= VMEAddr;
      end else if (w_rd_issue) begin
        r_rd_pend <= 1'b0;
      end
      if (VMEWrMem) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= VMEAddr;
        r_wr_data <= VMEWrData;
      end else if (w_wr_issue) begin
        r_wr_pend <= 1'b0;
      end
      r_rd_done <= w_rd_issue;
      r_wr_done <= w_wr_issue;
      if (w_rd_issue) r_rd_data <= r_mem[w_ram_addr];
    end
  end

  assign VMERdData   = r_rd_data;
  assign VMERdDone   = r_rd_done;
  assign VMEWrDone   = r_wr_done;
  assign acq_busy_o  = w_acq_active;
  assign acq_done_o  = (r_state == ST_DONE);
  assign wrapped_o   = r_wrapped;
  assign wr_ptr_o    = r_wr_ptr;
  assign trig_addr_o = r_trig_addr;

endmodule

// File: tb/tb_acq_viewport_ram.sv
// Bench for acq_viewport_ram: a 16-bit-address and a 4-bit-address instance
// share one stimulus stream and are checked every cycle against a capture model.
module tb_acq_viewport_ram;
  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] vme_addr = '0, vme_wdata = '0, acq_data = '0, post_trig = '0;
  logic        vme_rd = 1'b0, vme_wr = 1'b0, acq_valid = 1'b0, arm = 1'b0, trigger = 1'b0;

  always #5 Clk = ~Clk;

  logic [15:0] rdd0, rdd1, wp0, ta0;
  logic [3:0]  wp1, ta1;
  logic        rdn0, rdn1, wdn0, wdn1, bsy0, bsy1, dn0, dn1, wr0, wr1;

  acq_viewport_ram #(.ADDR_WIDTH(16)) u_dut (
    .Clk(Clk), .rst_n(rst_n), .VMEAddr(vme_addr), .VMEWrData(vme_wdata),
    .VMERdMem(vme_rd), .VMEWrMem(vme_wr), .VMERdData(rdd0), .VMERdDone(rdn0),
    .VMEWrDone(wdn0), .acq_data_i(acq_data), .acq_valid_i(acq_valid), .arm_i(arm),
    .trigger_i(trigger), .post_trig_i(post_trig), .acq_busy_o(bsy0), .acq_done_o(dn0),
    .wrapped_o(wr0), .wr_ptr_o(wp0), .trig_addr_o(ta0));

  acq_viewport_ram #(.ADDR_WIDTH(4)) u_dut4 (
    .Clk(Clk), .rst_n(rst_n), .VMEAddr(vme_addr[3:0]), .VMEWrData(vme_wdata),
    .VMERdMem(vme_rd), .VMEWrMem(vme_wr), .VMERdData(rdd1), .VMERdDone(rdn1),
    .VMEWrDone(wdn1), .acq_data_i(acq_data), .acq_valid_i(acq_valid), .arm_i(arm),
    .trigger_i(trigger), .post_trig_i(post_trig[3:0]), .acq_busy_o(bsy1), .acq_done_o(dn1),
    .wrapped_o(wr1), .wr_ptr_o(wp1), .trig_addr_o(ta1));

  logic [15:0] d_rdata [2], d_wptr [2], d_trig [2];
  logic        d_rdone [2], d_wdone [2], d_busy [2], d_done [2], d_wrap [2];
  assign d_rdata[0] = rdd0;  assign d_rdata[1] = rdd1;
  assign d_wptr[0]  = wp0;   assign d_wptr[1]  = {12'd0, wp1};
  assign d_trig[0]  = ta0;   assign d_trig[1]  = {12'd0, ta1};
  assign d_rdone[0] = rdn0;  assign d_rdone[1] = rdn1;
  assign d_wdone[0] = wdn0;  assign d_wdone[1] = wdn1;
  assign d_busy[0]  = bsy0;  assign d_busy[1]  = bsy1;
  assign d_done[0]  = dn0;   assign d_done[1]  = dn1;
  assign d_wrap[0]  = wr0;   assign d_wrap[1]  = wr1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Capture model: phase 0 idle, 1 armed, 2 triggered, 3 done.
  logic [15:0] m_mem   [2][65536];
  bit          m_known [2][65536];
  int          m_phase [2], m_ptr [2], m_trig [2], m_target [2], m_count [2];
  bit          m_wrapped [2], m_rp [2], m_wp [2];
  int          m_ra [2], m_wa [2];
  logic [15:0] m_wd [2];
  bit          e_rdone [2], e_wdone [2], e_rknown [2];
  logic [15:0] e_rdata [2];

  function automatic int dep(input int k);
    return (k == 0) ? 65536 : 16;
  endfunction

  always @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_ptr[k] = 0; m_trig[k] = 0; m_target[k] = 0; m_count[k] = 0;
        m_wrapped[k] = 0; m_rp[k] = 0; m_wp[k] = 0;
        e_rdone[k] = 0; e_wdone[k] = 0; e_rknown[k] = 0; e_rdata[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin : step
        int d;
        bit acq;
        d   = dep(k);
        acq = acq_valid && (m_phase[k] == 1 || m_phase[k] == 2) && !arm;
        e_rdone[k] = 0;
        e_wdone[k] = 0;
        if (!acq && m_rp[k]) begin
          e_rdone[k]  = 1;
          e_rdata[k]  = m_mem[k][m_ra[k]];
          e_rknown[k] = m_known[k][m_ra[k]];
          m_rp[k]     = 0;
        end else if (!acq && m_wp[k]) begin
          if (m_phase[k] == 0 || m_phase[k] == 3) begin
            m_mem[k][m_wa[k]]   = m_wd[k];
            m_known[k][m_wa[k]] = 1;
          end
          e_wdone[k] = 1;
          m_wp[k]    = 0;
        end
        if (arm) begin
          m_phase[k] = 1; m_ptr[k] = 0; m_wrapped[k] = 0; m_trig[k] = 0; m_count[k] = 0;
        end else begin
          if (m_phase[k] == 1 && trigger) begin
            m_trig[k]   = m_ptr[k];
            m_target[k] = (int'(post_trig) % d == 0) ? 1 : int'(post_trig) % d;
            m_count[k]  = 0;
            m_phase[k]  = 2;
          end
          if (acq) begin
            m_mem[k][m_ptr[k]]   = acq_data;
            m_known[k][m_ptr[k]] = 1;
            if (m_ptr[k] == d - 1) m_wrapped[k] = 1;
            m_ptr[k] = (m_ptr[k] + 1) % d;
            if (m_phase[k] == 2) begin
              m_count[k]++;
              if (m_count[k] == m_target[k]) m_phase[k] = 3;
            end
          end
        end
        if (vme_rd) begin m_rp[k] = 1; m_ra[k] = int'(vme_addr) % d; end
        if (vme_wr) begin m_wp[k] = 1; m_wa[k] = int'(vme_addr) % d; m_wd[k] = vme_wdata; end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("rd_done", k, d_rdone[k], e_rdone[k]);
        chk("wr_done", k, d_wdone[k], e_wdone[k]);
        chk("busy", k, d_busy[k], (m_phase[k] == 1 || m_phase[k] == 2));
        chk("done", k, d_done[k], (m_phase[k] == 3));
        chk("wrapped", k, d_wrap[k], m_wrapped[k]);
        chk("wr_ptr", k, d_wptr[k], m_ptr[k]);
        chk("trig_addr", k, d_trig[k], m_trig[k]);
        if (e_rdone[k] && e_rknown[k]) chk("rd_data", k, d_rdata[k], e_rdata[k]);
      end
    end
  end

  initial begin
    @(posedge Clk);
    #1 chk_en = 1'b1;
  end

  task automatic sample(input bit v, input logic [15:0] dat, input bit trg);
    acq_valid = v; acq_data = dat; trigger = trg;
    @(negedge Clk);
    acq_valid = 1'b0; trigger = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge Clk);
    arm = 1'b0;
  endtask

  task automatic vme_txn(input bit do_rd, input bit do_wr, input logic [15:0] a,
                         input logic [15:0] wd, output int rlat, output int wlat,
                         output logic [15:0] rd0, output logic [15:0] rd1);
    bit pend;
    rlat = do_rd ? 99 : 0;
    wlat = do_wr ? 99 : 0;
    rd0 = '0; rd1 = '0; pend = 1'b1;
    vme_rd = do_rd; vme_wr = do_wr; vme_addr = a; vme_wdata = wd;
    @(negedge Clk);
    vme_rd = 1'b0; vme_wr = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (do_rd && rlat == 99 && d_rdone[0]) begin
        rlat = n; rd0 = d_rdata[0]; rd1 = d_rdata[1];
      end
      if (do_wr && wlat == 99 && d_wdone[0]) wlat = n;
      pend = (do_rd && rlat == 99) || (do_wr && wlat == 99);
      if (!pend) break;
      @(negedge Clk);
    end
    chk("vme_complete", 0, pend, 0);
  endtask

  int rl, wl, n, cnt;
  logic [15:0] r0, r1;

  initial begin
    repeat (3) @(negedge Clk);
    rst_n = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", k, d_busy[k], 0);
      chk("reset_wr_ptr", k, d_wptr[k], 0);
      chk("reset_rd_data", k, d_rdata[k], 0);
    end

    // IDLE write / read, and read+write strobed together
    vme_txn(0, 1, 16'h0010, 16'hA5A5, rl, wl, r0, r1);
    chk("idle_wr_lat", 0, wl, 2);
    vme_txn(1, 0, 16'h0010, 16'h0000, rl, wl, r0, r1);
    chk("idle_rd_lat", 0, rl, 2);
    chk("idle_rd_data", 0, r0, 16'hA5A5);
    vme_txn(0, 1, 16'h0020, 16'h1111, rl, wl, r0, r1);
    vme_txn(1, 1, 16'h0020, 16'h5A5A, rl, wl, r0, r1);
    chk("dual_rd_lat", 0, rl, 2);
    chk("dual_wr_lat", 0, wl, 3);
    chk("dual_rd_old", 0, r0, 16'h1111);
    vme_txn(1, 0, 16'h0020, 16'h0000, rl, wl, r0, r1);
    chk("dual_rd_new", 0, r0, 16'h5A5A);
    vme_txn(0, 1, 16'd13, 16'hBEEF, rl, wl, r0, r1);

    // Capture: post=4, trigger with sample 9, sample 13 arrives after DONE
    post_trig = 16'd4;
    do_arm();
    for (int i = 0; i <= 13; i++) begin
      sample(1'b1, 16'(i), (i == 9));
      @(negedge Clk);
    end
    chk("cap_done", 0, d_done[0], 1);
    chk("cap_trig", 0, d_trig[0], 9);
    chk("cap_wr_ptr", 0, d_wptr[0], 13);
    chk("cap_wrapped", 0, d_wrap[0], 0);
    chk("model_cap_trig", 0, m_trig[0], 9);
    chk("model_cap_ptr", 0, m_ptr[0], 13);
    for (int a = 9; a <= 12; a++) begin
      vme_txn(1, 0, 16'(a), 16'h0000, rl, wl, r0, r1);
      chk("cap_readback", 0, r0, 32'(a));
    end
    vme_txn(1, 0, 16'd13, 16'h0000, rl, wl, r0, r1);
    chk("cap_not_written", 0, r0, 16'hBEEF);

    // Dropped write while ARMED, then a read colliding with a sample
    do_arm();
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, 16'(100 + i), 1'b0);
      @(negedge Clk);
    end
    vme_txn(0, 1, 16'd5, 16'h1234, rl, wl, r0, r1);
    chk("drop_wr_lat", 0, wl, 2);
    vme_rd = 1'b1; vme_addr = 16'd3;
    @(negedge Clk);
    vme_rd = 1'b0; acq_valid = 1'b1; acq_data = 16'd200;
    @(negedge Clk);
    acq_valid = 1'b0;
    n = 2;
    while (!d_rdone[0] && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("coll_rd_lat", 0, n, 3);
    chk("coll_rd_data", 0, d_rdata[0], 16'd103);
    post_trig = 16'd1;
    sample(1'b1, 16'd300, 1'b1);
    chk("post1_done", 0, d_done[0], 1);
    vme_txn(1, 0, 16'd5, 16'h0000, rl, wl, r0, r1);
    chk("drop_rd_data", 0, r0, 16'd105);

    // Wrap on the 16-deep instance: 20 samples, trigger with the 21st, post=0
    post_trig = 16'd0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      sample(1'b1, 16'(i), 1'b0);
      @(negedge Clk);
    end
    sample(1'b1, 16'd20, 1'b1);
    @(negedge Clk);
    sample(1'b1, 16'd21, 1'b0);
    chk("wrap_wrapped", 1, d_wrap[1], 1);
    chk("wrap_trig", 1, d_trig[1], 4);
    chk("wrap_wr_ptr", 1, d_wptr[1], 5);
    chk("wrap_done", 1, d_done[1], 1);
    chk("model_wrap_trig", 1, m_trig[1], 4);
    chk("nowrap_trig", 0, d_trig[0], 20);
    chk("nowrap_wr_ptr", 0, d_wptr[0], 21);
    vme_txn(1, 0, 16'd4, 16'h0000, rl, wl, r0, r1);
    chk("wrap_rd4", 1, r1, 16'd20);
    vme_txn(1, 0, 16'd5, 16'h0000, rl, wl, r0, r1);
    chk("wrap_rd5", 1, r1, 16'd5);
    vme_txn(1, 0, 16'd3, 16'h0000, rl, wl, r0, r1);
    chk("wrap_rd3", 1, r1, 16'd19);

    // Reset in the middle of a capture with a read in flight
    post_trig = 16'd3;
    do_arm();
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 16'(50 + i), 1'b0);
      @(negedge Clk);
    end
    vme_rd = 1'b1; vme_addr = 16'd1;
    @(negedge Clk);
    vme_rd = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, d_busy[k], 0);
      chk("rst_done", k, d_done[k], 0);
      chk("rst_wr_ptr", k, d_wptr[k], 0);
      chk("rst_rd_done", k, d_rdone[k], 0);
      chk("rst_rd_data", k, d_rdata[k], 0);
    end
    @(negedge Clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge Clk);
      if (d_rdone[0]) cnt++;
    end
    chk("rst_no_rd_done", 0, cnt, 0);

    // Randomized acquisition and VME traffic against the model
    fork
      begin
        bit prev;
        prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
          arm = ($urandom_range(0, 59) == 0);
          if (arm) begin
            acq_valid = 1'b0; trigger = 1'b0;
          end else begin
            acq_valid = !prev && ($urandom_range(0, 1) == 1);
            trigger   = ($urandom_range(0, 9) == 0);
          end
          acq_data  = 16'($urandom);
          post_trig = 16'($urandom_range(0, 5));
          prev = acq_valid;
          @(negedge Clk);
        end
        arm = 1'b0; acq_valid = 1'b0; trigger = 1'b0;
      end
      begin
        bit rr, ww;
        logic [15:0] q0, q1;
        int la, lb;
        for (int t = 0; t < 250; t++) begin
          rr = ($urandom_range(0, 1) == 1);
          ww = ($urandom_range(0, 1) == 1);
          if (!rr && !ww) rr = 1'b1;
          vme_txn(rr, ww, 16'($urandom_range(0, 31)), 16'($urandom), la, lb, q0, q1);
          repeat ($urandom_range(0, 3)) @(negedge Clk);
        end
      end
    join

    repeat (4) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
